// File: rtl/mux_tree_pkg.sv
// Shared constants and elaboration helpers for the pipelined radix-4 mux tree.
package mux_tree_pkg;

    localparam int RADIX = 4;

    // Number of radix-4 levels needed to reduce n channels to one.
    function automatic int clog4(input int n);
        int d;
        int v;
        d = 0;
        v = n;
        while (v > 1) begin
            v = v / RADIX;
            d++;
        end
        return d;
    endfunction

    function automatic bit is_pow4(input int n);
        int v;
        v = n;
        if (v < RADIX) return 1'b0;
        while (v > 1) begin
            if ((v % RADIX) != 0) return 1'b0;
            v = v / RADIX;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/mux_tree_pipe_mux4_stage.sv
// Registered 4:1 mux slice with valid pass-through; one tree node.
module mux4_stage
    import mux_tree_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [RADIX*WIDTH-1:0] d,
    input  logic [1:0]             s,
    input  logic                   vin,
    output logic [WIDTH-1:0]       q,
    output logic                   vout
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= '0;
            vout <= 1'b0;
        end else begin
            q    <= d[s*WIDTH +: WIDTH];
            vout <= vin;
        end
    end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined NUM_CH:1 radix-4 mux tree with valid tracking and auto-scan select.
// Build option MUX_TREE_HOLD_EN: y/y_sel hold their last valid values instead of reading 0.
module mux_tree_pipe
    import mux_tree_pkg::*;
#(
    parameter  int NUM_CH = 16,
    parameter  int WIDTH  = 1,
    localparam int SEL_W  = $clog2(NUM_CH),
    localparam int LEVELS = clog4(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    input  logic                    scan_en,
    output logic [WIDTH-1:0]        y,
    output logic [SEL_W-1:0]        y_sel,
    output logic                    out_valid
);

    if (!is_pow4(NUM_CH)) begin : g_bad_num_ch
        $error("mux_tree_pipe: NUM_CH must be 4, 16, 64 or 256");
    end

    logic [SEL_W-1:0] scan_cnt;
    logic [SEL_W-1:0] eff_sel;

    assign eff_sel = scan_en ? scan_cnt : sel;

    // NUM_CH is a power of two, so natural overflow gives the wrap to 0.
    always_ff @(posedge clk) begin
        if (rst)
            scan_cnt <= '0;
        else if (scan_en && in_valid)
            scan_cnt <= scan_cnt + SEL_W'(1);
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int N_OUT = NUM_CH >> (2*k);

        logic [RADIX*N_OUT*WIDTH-1:0] d_src;
        logic [N_OUT*WIDTH-1:0]       d_q;
        logic [SEL_W-1:0]             idx_src;
        logic [SEL_W-1:0]             idx_q;
        logic                         v_src;
        logic [N_OUT-1:0]             v_q;

        if (k == 1) begin : g_first
            assign d_src   = data;
            assign idx_src = eff_sel;
            assign v_src   = in_valid;
        end else begin : g_next
            assign d_src   = g_lvl[k-1].d_q;
            assign idx_src = g_lvl[k-1].idx_q;
            // every node in a level carries the same valid; AND keeps all of them live
            assign v_src   = &g_lvl[k-1].v_q;
        end

        for (genvar j = 0; j < N_OUT; j++) begin : g_mux
            mux4_stage #(.WIDTH(WIDTH)) u_mux (
                .clk  (clk),
                .rst  (rst),
                .d    (d_src[j*RADIX*WIDTH +: RADIX*WIDTH]),
                .s    (idx_src[2*k-1 -: 2]),
                .vin  (v_src),
                .q    (d_q[j*WIDTH +: WIDTH]),
                .vout (v_q[j])
            );
        end

        always_ff @(posedge clk) begin
            if (rst)
                idx_q <= '0;
            else
                idx_q <= idx_src;
        end
    end

    logic [WIDTH-1:0] y_raw;
    logic [SEL_W-1:0] sel_raw;

    assign y_raw     = g_lvl[LEVELS].d_q;
    assign sel_raw   = g_lvl[LEVELS].idx_q;
    assign out_valid = &g_lvl[LEVELS].v_q;

`ifdef MUX_TREE_HOLD_EN
    logic [WIDTH-1:0] y_hold;
    logic [SEL_W-1:0] sel_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_hold   <= '0;
            sel_hold <= '0;
        end else if (out_valid) begin
            y_hold   <= y_raw;
            sel_hold <= sel_raw;
        end
    end

    assign y     = out_valid ? y_raw   : y_hold;
    assign y_sel = out_valid ? sel_raw : sel_hold;
`else
    assign y     = out_valid ? y_raw   : '0;
    assign y_sel = out_valid ? sel_raw : '0;
`endif

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench: 16x1 and 64x8 mux trees driven with directed and random traffic.
module tb_mux_tree_pipe;

    localparam int N_A = 16, W_A = 1, SW_A = 4, L_A = 2;
    localparam int N_B = 64, W_B = 8, SW_B = 6, L_B = 3;

    typedef struct {
        int y;
        int sel;
        int due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    int   cnt_a = 0;
    int   cnt_b = 0;

    logic                  rst_a = 1'b1, vin_a = 1'b0, scan_a = 1'b0;
    logic [N_A*W_A-1:0]    data_a = '0;
    logic [SW_A-1:0]       sel_a = '0;
    logic [W_A-1:0]        y_a;
    logic [SW_A-1:0]       ysel_a;
    logic                  vout_a;

    logic                  rst_b = 1'b1, vin_b = 1'b0, scan_b = 1'b0;
    logic [N_B*W_B-1:0]    data_b = '0;
    logic [SW_B-1:0]       sel_b = '0;
    logic [W_B-1:0]        y_b;
    logic [SW_B-1:0]       ysel_b;
    logic                  vout_b;

    mux_tree_pipe #(.NUM_CH(N_A), .WIDTH(W_A)) dut_a (
        .clk(clk), .rst(rst_a), .data(data_a), .sel(sel_a), .in_valid(vin_a),
        .scan_en(scan_a), .y(y_a), .y_sel(ysel_a), .out_valid(vout_a)
    );

    mux_tree_pipe #(.NUM_CH(N_B), .WIDTH(W_B)) dut_b (
        .clk(clk), .rst(rst_b), .data(data_b), .sel(sel_b), .in_valid(vin_b),
        .scan_en(scan_b), .y(y_b), .y_sel(ysel_b), .out_valid(vout_b)
    );

    // ---------------- stimulus + reference model ----------------
    task automatic drive_a(input logic v, input int s, input logic sc, input logic [N_A*W_A-1:0] d);
        int eff;
        @(posedge clk); #1;
        rst_a = 1'b0; vin_a = v; sel_a = s[SW_A-1:0]; scan_a = sc; data_a = d;
        if (v) begin
            eff = sc ? cnt_a : s;
            q_a.push_back(exp_t'{int'(d[eff]), eff, cyc + L_A});
            if (sc) cnt_a = (cnt_a + 1) % N_A;
        end
    endtask

    task automatic drive_b(input logic v, input int s, input logic sc, input logic [N_B*W_B-1:0] d);
        int eff;
        @(posedge clk); #1;
        rst_b = 1'b0; vin_b = v; sel_b = s[SW_B-1:0]; scan_b = sc; data_b = d;
        if (v) begin
            eff = sc ? cnt_b : s;
            q_b.push_back(exp_t'{int'(d[eff*W_B +: W_B]), eff, cyc + L_B});
            if (sc) cnt_b = (cnt_b + 1) % N_B;
        end
    endtask

    // Results already visible this cycle survive; anything later dies with the reset edge.
    task automatic reset_a();
        @(posedge clk); #1;
        rst_a = 1'b1; vin_a = 1'b0;
        while (q_a.size() > 0 && q_a[$].due > cyc) void'(q_a.pop_back());
        cnt_a = 0;
        @(posedge clk); #1;
    endtask

    task automatic reset_b();
        @(posedge clk); #1;
        rst_b = 1'b1; vin_b = 1'b0;
        while (q_b.size() > 0 && q_b[$].due > cyc) void'(q_b.pop_back());
        cnt_b = 0;
        @(posedge clk); #1;
    endtask

    // ---------------- monitors ----------------
    int   last_y_a = 0, last_s_a = 0;
    exp_t e_a;
    always @(negedge clk) begin
        if (cyc >= 1) begin
            checks++;
            if (vout_a) begin
                if (q_a.size() == 0) begin
                    errors++;
                    $display("FAIL a_unexpected_valid cyc=%0d got y=%0d y_sel=%0d, required no output", cyc, y_a, ysel_a);
                end else begin
                    e_a = q_a.pop_front();
                    if (y_a !== W_A'(e_a.y) || ysel_a !== SW_A'(e_a.sel) || cyc != e_a.due) begin
                        errors++;
                        $display("FAIL a_result cyc=%0d got y=%0d y_sel=%0d, required y=%0d y_sel=%0d at cyc=%0d",
                                 cyc, y_a, ysel_a, e_a.y, e_a.sel, e_a.due);
                    end
                    last_y_a = e_a.y; last_s_a = e_a.sel;
                end
            end else begin
`ifdef MUX_TREE_HOLD_EN
                if (y_a !== W_A'(last_y_a) || ysel_a !== SW_A'(last_s_a)) begin
`else
                if (y_a !== '0 || ysel_a !== '0) begin
`endif
                    errors++;
                    $display("FAIL a_idle cyc=%0d got y=%0d y_sel=%0d valid=%0d, required idle value", cyc, y_a, ysel_a, vout_a);
                end
            end
            if (rst_a) begin last_y_a = 0; last_s_a = 0; end
        end
    end

    int   last_y_b = 0, last_s_b = 0;
    exp_t e_b;
    always @(negedge clk) begin
        if (cyc >= 1) begin
            checks++;
            if (vout_b) begin
                if (q_b.size() == 0) begin
                    errors++;
                    $display("FAIL b_unexpected_valid cyc=%0d got y=%0h y_sel=%0d, required no output", cyc, y_b, ysel_b);
                end else begin
                    e_b = q_b.pop_front();
                    if (y_b !== W_B'(e_b.y) || ysel_b !== SW_B'(e_b.sel) || cyc != e_b.due) begin
                        errors++;
                        $display("FAIL b_result cyc=%0d got y=%0h y_sel=%0d, required y=%0h y_sel=%0d at cyc=%0d",
                                 cyc, y_b, ysel_b, e_b.y, e_b.sel, e_b.due);
                    end
                    last_y_b = e_b.y; last_s_b = e_b.sel;
                end
            end else begin
`ifdef MUX_TREE_HOLD_EN
                if (y_b !== W_B'(last_y_b) || ysel_b !== SW_B'(last_s_b)) begin
`else
                if (y_b !== '0 || ysel_b !== '0) begin
`endif
                    errors++;
                    $display("FAIL b_idle cyc=%0d got y=%0h y_sel=%0d valid=%0d, required idle value", cyc, y_b, ysel_b, vout_b);
                end
            end
            if (rst_b) begin last_y_b = 0; last_s_b = 0; end
        end
    end

    // ---------------- test sequence ----------------
    logic [N_B*W_B-1:0] pat_b;

    initial begin
        repeat (2) @(posedge clk);

        // sel sweep over 0xAAAA
        for (int i = 0; i < 16; i++) drive_a(1'b1, i, 1'b0, 16'hAAAA);
        // auto-scan over 0x00FF, wraps after 16
        for (int i = 0; i < 20; i++) drive_a(1'b1, 0, 1'b1, 16'h00FF);
        // bubbles
        drive_a(1'b1, 3, 1'b0, 16'h0048);
        drive_a(1'b0, int'($urandom_range(0, 15)), 1'b0, 16'h0048);
        drive_a(1'b1, 5, 1'b0, 16'h0048);
        drive_a(1'b1, 6, 1'b0, 16'h0048);
        // reset right after two launches, then scan restarts from 0
        drive_a(1'b1, 2, 1'b0, 16'h0014);
        drive_a(1'b1, 4, 1'b0, 16'h0014);
        reset_a();
        for (int i = 0; i < 3; i++) drive_a(1'b1, 9, 1'b1, 16'h0005);
        // single result followed by idle cycles
        drive_a(1'b1, 0, 1'b0, 16'h0001);
        for (int i = 0; i < 4; i++) drive_a(1'b0, 0, 1'b0, 16'h0000);

        // random traffic with mode changes, bubbles and occasional resets
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) == 0) reset_a();
            else drive_a(($urandom_range(0, 3) != 0), int'($urandom_range(0, N_A-1)),
                         ($urandom_range(0, 2) == 0), 16'($urandom));
        end
        for (int i = 0; i < 6; i++) drive_a(1'b0, 0, 1'b0, 16'h0000);

        // wide tree: channel i = i + 8'h10, select the top channel
        for (int i = 0; i < N_B; i++) pat_b[i*W_B +: W_B] = W_B'(i + 16);
        drive_b(1'b1, 63, 1'b0, pat_b);
        drive_b(1'b1, 0, 1'b0, pat_b);
        for (int i = 0; i < 4; i++) drive_b(1'b0, 0, 1'b0, pat_b);
        for (int i = 0; i < 200; i++) begin
            for (int j = 0; j < N_B; j++) pat_b[j*W_B +: W_B] = W_B'($urandom);
            if ($urandom_range(0, 99) == 0) reset_b();
            else drive_b(($urandom_range(0, 3) != 0), int'($urandom_range(0, N_B-1)),
                         ($urandom_range(0, 2) == 0), pat_b);
        end
        for (int i = 0; i < 6; i++) drive_b(1'b0, 0, 1'b0, pat_b);

        @(posedge clk); #1;
        checks++;
        if (q_a.size() != 0) begin
            errors++;
            $display("FAIL a_drain got %0d outstanding results, required 0", q_a.size());
        end
        checks++;
        if (q_b.size() != 0) begin
            errors++;
            $display("FAIL b_drain got %0d outstanding results, required 0", q_b.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
